// File: rtl/ll8_to_axi64.sv
`default_nettype none
// ============================================================================
// Module   : ll8_to_axi64
// Purpose  : Receive-side width converter for the simple GEMAC path. Packs an
//            8-bit LocalLink byte stream coming out of the MAC RX into 64-bit
//            AXI-Stream words.
//
//            Lane convention (shared with the TX-side converter):
//              - lane 0 is tdata[63:56], lane 7 is tdata[7:0];
//              - the first byte of every packet lands in lane START_BYTE, and
//                lanes 0..START_BYTE-1 of that first word read as zero;
//              - the last word of a packet carries, in tuser[2:0], the code
//                (lane of last byte + 1) mod 8 (0 = all eight lanes valid),
//                and in tuser[3] the packet error flag.
//
//            A single output word register sits between the packer and the
//            AXI side. Because ll_dst_rdy is asserted whenever that register
//            is empty or draining, a byte that completes a word can always be
//            loaded on the same edge, so 1 byte/cycle is sustained while the
//            sink keeps tready high.
//
// Ports    : clk           system clock, rising edge
//            reset         synchronous active-high reset
//            clear         synchronous active-high flush (same effect as reset)
//            ll_data       received byte
//            ll_eof        last byte of a packet
//            ll_error      packet error, may be flagged on any byte
//            ll_src_rdy    upstream byte valid
//            ll_dst_rdy    this block can accept a byte
//            axi64_tdata   packed 64-bit word
//            axi64_tlast   last word of a packet
//            axi64_tuser   {error, last-lane code} on tlast, 0 otherwise
//            axi64_tvalid  output word valid
//            axi64_tready  downstream accept
//
// Revision : 1.0  initial release
// ============================================================================
module ll8_to_axi64 #(
    parameter int START_BYTE = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  ll_data,
    input  logic        ll_eof,
    input  logic        ll_error,
    input  logic        ll_src_rdy,
    output logic        ll_dst_rdy,
    output logic [63:0] axi64_tdata,
    output logic        axi64_tlast,
    output logic [3:0]  axi64_tuser,
    output logic        axi64_tvalid,
    input  logic        axi64_tready
);

    // Lane that receives the first byte of every packet.
    localparam logic [2:0] c_start_lane = START_BYTE[2:0];

    // ------------------------------------------------------------------------
    // Packing state
    // ------------------------------------------------------------------------
    logic [2:0]  r_lane;     // lane the next accepted byte is written to
    logic [63:0] r_acc;      // partially filled word, unused lanes are zero
    logic        r_err;      // sticky error for the packet in progress

    // ------------------------------------------------------------------------
    // Output word register
    // ------------------------------------------------------------------------
    logic [63:0] r_tdata;
    logic        r_tlast;
    logic [3:0]  r_tuser;
    logic        r_tvalid;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic        w_dst_rdy;
    logic        w_accept;
    logic        w_flush;
    logic [5:0]  w_lane_shift;
    logic [63:0] w_byte_word;
    logic [63:0] w_merged;
    logic        w_complete;
    logic        w_err_now;
    logic [2:0]  w_lane_inc;

    always_comb begin
        // The output register can take a new word if it is empty or is
        // being emptied on this very edge.
        w_dst_rdy    = ~r_tvalid | axi64_tready;
        w_accept     = ll_src_rdy & w_dst_rdy;
        w_flush      = reset | clear;

        // Lane n occupies bits [63-8n -: 8], i.e. the byte is shifted left by
        // 8*(7-n). For a 3-bit lane index, 7-n is simply the bit inversion.
        w_lane_shift = {~r_lane, 3'b000};
        w_byte_word  = {56'd0, ll_data} << w_lane_shift;
        w_merged     = r_acc | w_byte_word;

        // A word is finished when its last lane is filled or the packet ends.
        w_complete   = w_accept & (ll_eof | (r_lane == 3'd7));

        // Error seen so far in the packet, including the current byte.
        w_err_now    = r_err | ll_error;

        // Natural 3-bit wrap gives both the 7->0 lane increment and the
        // (lane + 1) mod 8 valid-byte code for the last word.
        w_lane_inc   = r_lane + 3'd1;
    end

    assign ll_dst_rdy   = w_dst_rdy;
    assign axi64_tdata  = r_tdata;
    assign axi64_tlast  = r_tlast;
    assign axi64_tuser  = r_tuser;
    assign axi64_tvalid = r_tvalid;

    // ------------------------------------------------------------------------
    // Packing state update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_lane <= c_start_lane;
            r_acc  <= 64'd0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            // The accumulator restarts from zero whenever its contents move
            // to the output register, so stale bytes never leak into the
            // unused lanes of a later word.
            if (w_complete) begin
                r_acc <= 64'd0;
            end else begin
                r_acc <= w_merged;
            end

            if (ll_eof) begin
                r_lane <= c_start_lane;
                r_err  <= 1'b0;
            end else begin
                r_lane <= w_lane_inc;
                r_err  <= w_err_now;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register update
    // ------------------------------------------------------------------------
    // A completing byte is only ever accepted while the register is empty or
    // draining, so loading here never overwrites an unconsumed word. When a
    // word is pending and tready is low, nothing in this block changes, which
    // keeps tdata/tlast/tuser stable as AXI requires.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_tdata  <= 64'd0;
            r_tlast  <= 1'b0;
            r_tuser  <= 4'd0;
            r_tvalid <= 1'b0;
        end else if (w_complete) begin
            r_tdata  <= w_merged;
            r_tlast  <= ll_eof;
            r_tuser  <= ll_eof ? {w_err_now, w_lane_inc} : 4'd0;
            r_tvalid <= 1'b1;
        end else if (axi64_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ll8_to_axi64.sv
`default_nettype none
// ============================================================================
// Module   : tb_ll8_to_axi64
// Purpose  : Self-checking bench for ll8_to_axi64 (START_BYTE = 6). A
//            cycle-by-cycle vector table covers the basic packing and the
//            output-register handshake; hand-written sequences cover the
//            multi-cycle cases (sink stall, back-to-back packets, error flag,
//            aborted packets via clear and reset).
// Revision : 1.0  initial release
// ============================================================================
module tb_ll8_to_axi64;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [7:0]  ll_data;
    logic        ll_eof;
    logic        ll_error;
    logic        ll_src_rdy;
    logic        ll_dst_rdy;
    logic [63:0] axi64_tdata;
    logic        axi64_tlast;
    logic [3:0]  axi64_tuser;
    logic        axi64_tvalid;
    logic        axi64_tready;

    ll8_to_axi64 #(.START_BYTE(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .ll_data      (ll_data),
        .ll_eof       (ll_eof),
        .ll_error     (ll_error),
        .ll_src_rdy   (ll_src_rdy),
        .ll_dst_rdy   (ll_dst_rdy),
        .axi64_tdata  (axi64_tdata),
        .axi64_tlast  (axi64_tlast),
        .axi64_tuser  (axi64_tuser),
        .axi64_tvalid (axi64_tvalid),
        .axi64_tready (axi64_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Output monitor: records every completed AXI transfer
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [3:0]  u;
        int          c;
    } obs_t;

    obs_t obs_q[$];

    always @(negedge clk) begin
        if (axi64_tvalid && axi64_tready && !reset && !clear)
            obs_q.push_back('{axi64_tdata, axi64_tlast, axi64_tuser, cyc});
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [63:0] exp_d [0:3];
    logic        exp_l [0:3];
    logic [3:0]  exp_u [0:3];

    task automatic set_exp(input int i, input logic [63:0] d, input logic l, input logic [3:0] u);
        exp_d[i] = d;
        exp_l[i] = l;
        exp_u[i] = u;
    endtask

    // Compare the recorded transfers against exp_*[0..n-1], then flush.
    task automatic check_words(input string tag, input int n);
        check({tag, " word count"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            check($sformatf("%s w%0d tdata", tag, i), obs_q[i].d, exp_d[i]);
            check($sformatf("%s w%0d tlast", tag, i), 64'(obs_q[i].l), 64'(exp_l[i]));
            check($sformatf("%s w%0d tuser", tag, i), 64'(obs_q[i].u), 64'(exp_u[i]));
        end
        obs_q.delete();
    endtask

    // All sequences run aligned to 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] pkt [0:15];

    task automatic send_pkt(input int len, input int err_idx, input bit with_eof);
        bit done;
        int guard;
        for (int i = 0; i < len; i++) begin
            ll_data    = pkt[i];
            ll_eof     = with_eof && (i == len - 1);
            ll_error   = (i == err_idx);
            ll_src_rdy = 1'b1;
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                @(negedge clk);
                done = ll_dst_rdy;
                @(posedge clk);
                #1;
                guard++;
                if (!done && guard > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send timeout: byte %0d not accepted in %0d cycles", i, guard);
                    done = 1'b1;
                end
            end
        end
        ll_src_rdy = 1'b0;
        ll_eof     = 1'b0;
        ll_error   = 1'b0;
    endtask

    task automatic load_ramp(input logic [7:0] base, input int len);
        for (int i = 0; i < len; i++) pkt[i] = base + 8'(i);
    endtask

    // ------------------------------------------------------------------------
    // Cycle-by-cycle vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0]  data;
        logic        eof;
        logic        src;
        logic        tready;
        logic        exp_rdy;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_last;
        logic [3:0]  exp_user;
    } vec_t;

    vec_t vt [0:17];

    function automatic vec_t mkv(input logic [7:0] data, input logic eof, input logic src,
                                 input logic tready, input logic exp_rdy, input logic exp_valid,
                                 input logic [63:0] exp_data, input logic exp_last,
                                 input logic [3:0] exp_user);
        vec_t v;
        v.data = data; v.eof = eof; v.src = src; v.tready = tready;
        v.exp_rdy = exp_rdy; v.exp_valid = exp_valid; v.exp_data = exp_data;
        v.exp_last = exp_last; v.exp_user = exp_user;
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        //              data   eof  src  trdy rdy  vld  tdata                  last usr
        // 10-byte packet 0x10..0x19 at full throughput
        vt[0]  = mkv(8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[1]  = mkv(8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[2]  = mkv(8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_1011, 1'b0, 4'h0);
        vt[3]  = mkv(8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[4]  = mkv(8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[5]  = mkv(8'h15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[6]  = mkv(8'h16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[7]  = mkv(8'h17, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[8]  = mkv(8'h18, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[9]  = mkv(8'h19, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[10] = mkv(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1213_1415_1617_1819, 1'b1, 4'h0);
        vt[11] = mkv(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        // Single-byte packets against a stalling sink
        vt[12] = mkv(8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);
        vt[13] = mkv(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_7700, 1'b1, 4'h7);
        vt[14] = mkv(8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_7700, 1'b1, 4'h7);
        vt[15] = mkv(8'h88, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_7700, 1'b1, 4'h7);
        vt[16] = mkv(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_8800, 1'b1, 4'h7);
        vt[17] = mkv(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0,                 1'b0, 4'h0);

        reset        = 1'b1;
        clear        = 1'b0;
        ll_data      = 8'h00;
        ll_eof       = 1'b0;
        ll_error     = 1'b0;
        ll_src_rdy   = 1'b0;
        axi64_tready = 1'b1;

        // ---------------- reset state ----------------
        @(posedge clk);
        @(negedge clk);
        check("reset tvalid", 64'(axi64_tvalid), 64'd0);
        check("reset tdata",  axi64_tdata,       64'd0);
        check("reset tlast",  64'(axi64_tlast),  64'd0);
        check("reset tuser",  64'(axi64_tuser),  64'd0);
        check("reset dst_rdy", 64'(ll_dst_rdy),  64'd1);
        idle(2);
        reset = 1'b0;
        idle(1);
        obs_q.delete();

        // ---------------- vector table ----------------
        for (int i = 0; i < 18; i++) begin
            ll_data      = vt[i].data;
            ll_eof       = vt[i].eof;
            ll_error     = 1'b0;
            ll_src_rdy   = vt[i].src;
            axi64_tready = vt[i].tready;
            @(negedge clk);
            check($sformatf("vec%0d dst_rdy", i), 64'(ll_dst_rdy),   64'(vt[i].exp_rdy));
            check($sformatf("vec%0d tvalid", i),  64'(axi64_tvalid), 64'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                check($sformatf("vec%0d tdata", i), axi64_tdata,       vt[i].exp_data);
                check($sformatf("vec%0d tlast", i), 64'(axi64_tlast),  64'(vt[i].exp_last));
                check($sformatf("vec%0d tuser", i), 64'(axi64_tuser),  64'(vt[i].exp_user));
            end
            @(posedge clk);
            #1;
        end
        ll_src_rdy   = 1'b0;
        ll_eof       = 1'b0;
        axi64_tready = 1'b1;
        idle(2);
        obs_q.delete();

        // ---------------- 3-byte packet ----------------
        pkt[0] = 8'hA0; pkt[1] = 8'hA1; pkt[2] = 8'hA2;
        send_pkt(3, -1, 1'b1);
        idle(4);
        set_exp(0, 64'h0000_0000_0000_A0A1, 1'b0, 4'h0);
        set_exp(1, 64'hA200_0000_0000_0000, 1'b1, 4'h1);
        check_words("pkt3", 2);

        // ---------------- back-to-back 1-byte packets ----------------
        pkt[0] = 8'h55; pkt[1] = 8'h66;
        ll_data = 8'h55; ll_eof = 1'b1; ll_src_rdy = 1'b1;
        idle(1);
        ll_data = 8'h66;
        idle(1);
        ll_src_rdy = 1'b0; ll_eof = 1'b0;
        idle(4);
        check("b2b word count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2)
            check("b2b no bubble", 64'(obs_q[1].c - obs_q[0].c), 64'd1);
        set_exp(0, 64'h0000_0000_0000_5500, 1'b1, 4'h7);
        set_exp(1, 64'h0000_0000_0000_6600, 1'b1, 4'h7);
        check_words("b2b", 2);

        // ---------------- 10-byte packet with sink stall ----------------
        load_ramp(8'h10, 10);
        axi64_tready = 1'b0;
        fork
            send_pkt(10, -1, 1'b1);
            begin
                int w;
                w = 0;
                while (!axi64_tvalid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("stall word0 appears", 64'(axi64_tvalid), 64'd1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d dst_rdy", k), 64'(ll_dst_rdy), 64'd0);
                    check($sformatf("stall%0d tdata", k), axi64_tdata, 64'h0000_0000_0000_1011);
                    @(posedge clk);
                    #1;
                end
                axi64_tready = 1'b1;
            end
        join
        idle(4);
        set_exp(0, 64'h0000_0000_0000_1011, 1'b0, 4'h0);
        set_exp(1, 64'h1213_1415_1617_1819, 1'b1, 4'h0);
        check_words("stall", 2);

        // ---------------- error on byte 4, then clean packet ----------------
        load_ramp(8'h10, 10);
        send_pkt(10, 4, 1'b1);
        idle(4);
        set_exp(0, 64'h0000_0000_0000_1011, 1'b0, 4'h0);
        set_exp(1, 64'h1213_1415_1617_1819, 1'b1, 4'h8);
        check_words("err", 2);
        pkt[0] = 8'hA0; pkt[1] = 8'hA1; pkt[2] = 8'hA2;
        send_pkt(3, -1, 1'b1);
        idle(4);
        set_exp(0, 64'h0000_0000_0000_A0A1, 1'b0, 4'h0);
        set_exp(1, 64'hA200_0000_0000_0000, 1'b1, 4'h1);
        check_words("after err", 2);

        // ---------------- aborted packet via clear, then via reset ----------------
        for (int pass = 0; pass < 2; pass++) begin
            load_ramp(8'h30, 5);
            send_pkt(5, 2, 1'b0);
            idle(4);
            obs_q.delete();
            if (pass == 0) clear = 1'b1;
            else           reset = 1'b1;
            idle(1);
            clear = 1'b0;
            reset = 1'b0;
            pkt[0] = 8'hA0; pkt[1] = 8'hA1; pkt[2] = 8'hA2;
            send_pkt(3, -1, 1'b1);
            idle(4);
            set_exp(0, 64'h0000_0000_0000_A0A1, 1'b0, 4'h0);
            set_exp(1, 64'hA200_0000_0000_0000, 1'b1, 4'h1);
            check_words(pass == 0 ? "abort clear" : "abort reset", 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ll8_to_axi64.md
Name: ll8_to_axi64

Overview:
- Receive-side width converter for the simple GEMAC path.
- Packs an 8-bit LocalLink byte stream from the MAC RX into 64-bit AXI-Stream words.
- Uses the same lane convention as the TX-side converter:
  - the first byte of a packet lands in lane START_BYTE;
  - lane 0 is tdata[63:56] and lane 7 is tdata[7:0];
  - the last word carries a valid-byte code and an error flag in tuser.
- Includes a one-word output register, so the block sustains 1 byte/cycle under full downstream throughput.

Parameters:
START_BYTE, 6, lane (0..7) receiving the first byte of each packet; lanes 0..START_BYTE-1 of the first word are zero padding

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; returns the block to idle
clear  input  1  synchronous, active-high; same effect as reset on packing state and output register
ll_data  input  8  received byte
ll_eof  input  1  marks the last byte of a packet
ll_error  input  1  packet error (CRC, overrun); valid on any byte of the packet
ll_src_rdy  input  1  upstream byte valid
ll_dst_rdy  output  1  block can accept a byte
axi64_tdata  output  64  packed word
axi64_tlast  output  1  last word of packet
axi64_tuser  output  4  [2:0] = (lane of last byte + 1) mod 8, valid on tlast; [3] = packet error, valid on tlast; all 4 bits are 0 on non-last words
axi64_tvalid  output  1  output word valid
axi64_tready  input  1  downstream accept

Behaviour:
- Reset/clear (both synchronous, active-high, equal priority, override all other activity):
  - Lane counter goes to START_BYTE; accumulator cleared to 0; sticky error cleared.
  - Output register invalidated: tvalid=0, tlast=0, tuser=0, tdata=0.
  - Any partial or pending packet is discarded; no word is emitted for it.
  - Next accepted byte is treated as the first byte of a new packet.
- Handshake:
  - ll_dst_rdy = ~axi64_tvalid | axi64_tready, combinational.
  - A byte is accepted when ll_src_rdy & ll_dst_rdy.
  - An output word transfers when axi64_tvalid & axi64_tready.
  - AXI rule: once tvalid=1, tdata, tlast and tuser are held stable until tready.
- Lane counter:
  - 3-bit; the accepted byte is written to lane[counter], i.e. bits [63-8*counter -: 8].
  - On accept without eof: counter increments, wrapping from 7 to 0.
  - On accept with eof: counter returns to START_BYTE.
- Word completion:
  - A word completes when the accepted byte is in lane 7, or the byte carries ll_eof.
  - The complete word (accumulator merged with the current byte) loads the output register on that cycle's clock edge.
  - tvalid asserts the next cycle; latency is 1 cycle from the completing byte to tvalid.
  - The accumulator clears to 0 on the same edge, so unused lanes of every emitted word read 0.
- A completing byte is always accepted only when the output register is free or draining, because ll_dst_rdy already includes that condition. No overflow is possible.
- tlast is set when the word was completed by ll_eof.
- tuser[2:0] on the last word = (lane of last byte + 1) mod 8:
  - 0 means all 8 lanes are valid;
  - e.g. last byte in lane 2 -> tuser[2:0]=3.
  - This is exactly the code the TX converter consumes.
- Error flag:
  - The sticky error is ORed with ll_error on every accepted byte.
  - tuser[3] = sticky | ll_error on the eof byte.
  - The sticky flag clears when the eof byte is accepted.
- Output register update:
  - If tready is high and no new word completes, tvalid drops to 0.
  - A simultaneous drain and load is a back-to-back transfer; tvalid stays 1 with the new word.
- Edge cases:
  - Single-byte packet: one word, tlast=1, tuser[2:0]=START_BYTE+1 mod 8.
  - ll_src_rdy low mid-packet: state is held indefinitely, with no timeout.

Test Plan:
- 10-byte packet B0..B9 (0x10..0x19), START_BYTE=6, tready=1 -> exactly two output words:
  - word0 = 0x0000_0000_0000_1011, tlast=0, tuser=0;
  - word1 = 0x1213_1415_1617_1819, tlast=1, tuser=0x0.
- 3-byte packet 0xA0,0xA1,0xA2:
  - word0 = 0x...A0A1 in lanes 6,7;
  - word1 = 0xA200_0000_0000_0000, tlast=1, tuser=0x1.
- 1-byte packet 0x55 -> single word 0x0000_0000_0000_5500, tlast=1, tuser=0x7. Back-to-back with a second 1-byte packet 0x66 -> two consecutive tvalid cycles with no bubbles.
- 10-byte packet with tready held 0 for 5 cycles while word0 is pending -> ll_dst_rdy=0 during the hold; no byte lost or duplicated; output matches scenario 1.
- 10-byte packet with ll_error=1 only on byte 4 -> last word tuser=0x8. The following clean packet -> tuser[3]=0.
- Assert clear after 5 bytes of a packet, then send a clean 3-byte packet -> no word from the aborted packet; the 3-byte packet matches scenario 2. Repeat using reset instead of clear -> same result.
